imm_encoder: RTL and testbench

- Iterative encoder that converts a 32-bit constant into the ARM data-processing rotated-immediate form {rot[3:0], imm8[7:0]}, where value = imm8 ROR (2*rot).
- It is the inverse of the datapath shifter's ROR immediate expansion.
- Used by the micro-program loader and assembler-support logic to decide whether a constant is encodable, and how.
- Tests one rotation per cycle behind valid/ready handshakes. Optionally also tries the bitwise inverse, for MVN/BIC substitution.

---
 rtl/imm_encoder.sv | 154 +++++++++++++++
 tb/tb_imm_encoder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder
// -----------
// Finds the ARM data-processing rotated-immediate form of a 32-bit constant:
// value == imm8 ROR (2*rot). One rotation is tried per clock, from rot=0
// upward. The first rotation that fits wins, so the result is canonical.
// At equal rotation the plain form beats the inverted (MVN/BIC) form.
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer holds valid and its payload
// until that transfer. The consumer may drop ready at any time. in_ready
// is high only when idle, so a new request is not accepted until the
// previous result has been retired.
//
// Parameters:
//   EN_MVN     1: also try ~value at each rotation. 0: out_mvn is always 0.
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   request valid
//   in_ready   encoder idle and able to accept
//   in_value   constant to encode
//   out_valid  result valid (high while in DONE)
//   out_ready  consumer accepts result
//   out_found  an encoding exists
//   out_mvn    encoding applies to ~in_value
//   out_rot    rotation field; the rotate amount is 2*out_rot
//   out_imm8   8-bit immediate field
module imm_encoder #(
    parameter bit EN_MVN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_found,
    output logic        out_mvn,
    output logic [3:0]  out_rot,
    output logic [7:0]  out_imm8
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] value_q, value_d;
    logic [3:0]  r_q, r_d;
    logic        found_q, found_d;
    logic        mvn_q, mvn_d;
    logic [3:0]  rot_q, rot_d;
    logic [7:0]  imm8_q, imm8_d;

    // Rotate left by 2*r. The top half of {v,v} << s is v ROL s, and this
    // also holds for s == 0.
    logic [4:0]  rot_amt;
    logic [63:0] dbl_p, dbl_n;
    logic [31:0] cand_p, cand_n;
    logic        plain_hit, mvn_hit;

    always_comb begin
        rot_amt   = {r_q, 1'b0};
        dbl_p     = {value_q, value_q} << rot_amt;
        dbl_n     = {~value_q, ~value_q} << rot_amt;
        cand_p    = dbl_p[63:32];
        cand_n    = dbl_n[63:32];
        plain_hit = (cand_p[31:8] == 24'd0);
        mvn_hit   = EN_MVN && (cand_n[31:8] == 24'd0);
    end

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        r_d     = r_q;
        found_d = found_q;
        mvn_d   = mvn_q;
        rot_d   = rot_q;
        imm8_d  = imm8_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    value_d = in_value;
                    r_d     = 4'd0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (plain_hit) begin
                    found_d = 1'b1;
                    mvn_d   = 1'b0;
                    rot_d   = r_q;
                    imm8_d  = cand_p[7:0];
                    state_d = DONE;
                end else if (mvn_hit) begin
                    found_d = 1'b1;
                    mvn_d   = 1'b1;
                    rot_d   = r_q;
                    imm8_d  = cand_n[7:0];
                    state_d = DONE;
                end else if (r_q == 4'd15) begin
                    found_d = 1'b0;
                    mvn_d   = 1'b0;
                    rot_d   = 4'd0;
                    imm8_d  = 8'd0;
                    state_d = DONE;
                end else begin
                    r_d = r_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            value_q <= 32'd0;
            r_q     <= 4'd0;
            found_q <= 1'b0;
            mvn_q   <= 1'b0;
            rot_q   <= 4'd0;
            imm8_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            r_q     <= r_d;
            found_q <= found_d;
            mvn_q   <= mvn_d;
            rot_q   <= rot_d;
            imm8_q  <= imm8_d;
        end
    end

    // Decoded straight from the state register. A reset clears these at
    // once, and they cannot glitch while the state is held in DONE.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_found = found_q;
    assign out_mvn   = mvn_q;
    assign out_rot   = rot_q;
    assign out_imm8  = imm8_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder. Two instances (EN_MVN=1 and EN_MVN=0) share one
// request stream and one out_ready. Each instance has its own expected queue.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_value;
    logic        out_ready;

    logic        in_ready1, out_valid1, out_found1, out_mvn1;
    logic [3:0]  out_rot1;
    logic [7:0]  out_imm8_1;
    logic        in_ready0, out_valid0, out_found0, out_mvn0;
    logic [3:0]  out_rot0;
    logic [7:0]  out_imm8_0;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    bit rand_ready   = 1'b1;

    // Expected {found, mvn, rot, imm8} and the cycle count at which valid rises.
    logic [13:0] exp_q1[$];
    logic [13:0] exp_q0[$];
    int          due_q1[$];
    int          due_q0[$];
    logic        pv[2];
    logic [13:0] held[2];

    imm_encoder #(.EN_MVN(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready1), .in_value(in_value),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_found(out_found1), .out_mvn(out_mvn1),
        .out_rot(out_rot1), .out_imm8(out_imm8_1)
    );

    imm_encoder #(.EN_MVN(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready0), .in_value(in_value),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_found(out_found0), .out_mvn(out_mvn0),
        .out_rot(out_rot0), .out_imm8(out_imm8_0)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input int s);
        logic [63:0] t;
        t = {x, x} << s;
        return t[63:32];
    endfunction

    function automatic logic [31:0] ror(input logic [31:0] x, input int s);
        logic [63:0] t;
        t = {x, x} >> s;
        return t[31:0];
    endfunction

    // Reference model: the smallest rot for which some imm8 ROR 2*rot gives
    // the value back. The plain value is tried before the inverse.
    function automatic logic [13:0] model(input logic [31:0] v, input bit en_mvn, output int lat);
        logic [31:0] t;
        logic [7:0]  ip;
        logic [3:0]  r4;
        for (int r = 0; r < 16; r++) begin
            r4 = r[3:0];
            t  = rol(v, 2 * r);
            ip = t[7:0];
            if (ror({24'd0, ip}, 2 * r) == v) begin
                lat = r + 1;
                return {1'b1, 1'b0, r4, ip};
            end
            if (en_mvn) begin
                t  = rol(~v, 2 * r);
                ip = t[7:0];
                if (ror({24'd0, ip}, 2 * r) == ~v) begin
                    lat = r + 1;
                    return {1'b1, 1'b1, r4, ip};
                end
            end
        end
        lat = 16;
        return 14'd0;
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic [31:0] v);
        int n;
        int lat;
        logic [13:0] e;
        n = 0;
        @(negedge clk);
        while (!(in_ready1 && in_ready0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            fail_now("wait_idle");
            return;
        end
        in_valid = 1'b1;
        in_value = v;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_value = $urandom;   // junk while the search runs
        e = model(v, 1'b1, lat);
        exp_q1.push_back(e);
        due_q1.push_back(cyc + lat);
        e = model(v, 1'b0, lat);
        exp_q0.push_back(e);
        due_q0.push_back(cyc + lat);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q1.size() != 0 || exp_q0.size() != 0 || !in_ready1 || !in_ready0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) fail_now("drain");
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic mon(input int id, input logic v, input logic rdy, input logic [13:0] res);
        logic [13:0] e;
        int d;
        bit have;
        if (v) begin
            chk($sformatf("in_ready_busy%0d", id), {31'd0, rdy}, 32'd0);
            if (!pv[id]) begin
                have = (id == 1) ? (exp_q1.size() != 0) : (exp_q0.size() != 0);
                if (!have) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_result%0d: got 0x%0h, expected none", id, res);
                end else begin
                    if (id == 1) begin
                        e = exp_q1.pop_front();
                        d = due_q1.pop_front();
                    end else begin
                        e = exp_q0.pop_front();
                        d = due_q0.pop_front();
                    end
                    chk($sformatf("result%0d", id), {18'd0, res}, {18'd0, e});
                    chk($sformatf("latency%0d", id), cyc, d);
                end
                held[id] = res;
            end else begin
                chk($sformatf("hold%0d", id), {18'd0, res}, {18'd0, held[id]});
            end
        end
        pv[id] = v;
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            pv[0] = 1'b0;
            pv[1] = 1'b0;
        end else begin
            mon(1, out_valid1, in_ready1, {out_found1, out_mvn1, out_rot1, out_imm8_1});
            mon(0, out_valid0, in_ready0, {out_found0, out_mvn0, out_rot0, out_imm8_0});
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [31:0] v;
        logic [7:0]  imm;
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_value  = 32'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready1", {31'd0, in_ready1}, 32'd1);
        chk("rst_in_ready0", {31'd0, in_ready0}, 32'd1);
        chk("rst_out_valid1", {31'd0, out_valid1}, 32'd0);
        chk("rst_out_valid0", {31'd0, out_valid0}, 32'd0);
        chk("rst_fields1", {18'd0, out_found1, out_mvn1, out_rot1, out_imm8_1}, 32'd0);
        chk("rst_fields0", {18'd0, out_found0, out_mvn0, out_rot0, out_imm8_0}, 32'd0);
        reset_n = 1'b1;

        // Directed corners.
        send(32'h0000_00FF);
        send(32'hFF00_0000);
        send(32'h0000_03FC);
        send(32'hFFFF_FF00);
        send(32'h0000_0000);
        send(32'h0000_0101);
        send(32'hFFFF_FFFF);
        send(32'h8000_0001);
        drain();

        // Stall: the result is held and new requests are ignored.
        rand_ready = 1'b0;
        out_ready  = 1'b0;
        send(32'hFF00_0000);
        n = 0;
        while (!out_valid1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) fail_now("stall_wait_valid");
        repeat (10) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_value = $urandom;
            chk("stall_valid1", {31'd0, out_valid1}, 32'd1);
            chk("stall_in_ready1", {31'd0, in_ready1}, 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("retire_valid1", {31'd0, out_valid1}, 32'd0);
        chk("retire_in_ready1", {31'd0, in_ready1}, 32'd1);
        rand_ready = 1'b1;
        drain();

        // Reset mid-search (r == 7).
        send(32'h0000_03FC);
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_search_valid1", {31'd0, out_valid1}, 32'd0);
        chk("rst_search_in_ready1", {31'd0, in_ready1}, 32'd1);
        chk("rst_search_in_ready0", {31'd0, in_ready0}, 32'd1);
        exp_q1.delete();
        exp_q0.delete();
        due_q1.delete();
        due_q0.delete();
        @(negedge clk);
        reset_n = 1'b1;

        // Reset while holding a result in DONE.
        rand_ready = 1'b0;
        out_ready  = 1'b0;
        send(32'h0000_00FF);
        n = 0;
        while (!out_valid1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) fail_now("done_wait_valid");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_done_valid1", {31'd0, out_valid1}, 32'd0);
        chk("rst_done_valid0", {31'd0, out_valid0}, 32'd0);
        chk("rst_done_found1", {31'd0, out_found1}, 32'd0);
        exp_q1.delete();
        exp_q0.delete();
        due_q1.delete();
        due_q0.delete();
        @(negedge clk);
        reset_n    = 1'b1;
        rand_ready = 1'b1;
        send(32'h0000_00FF);
        drain();

        // Randomised mix: plain encodable, inverted encodable, narrow spans, random.
        for (int i = 0; i < 40; i++) begin
            imm = $urandom_range(0, 255);
            case ($urandom_range(0, 3))
                0: v = ror({24'd0, imm}, 2 * $urandom_range(0, 15));
                1: v = ~ror({24'd0, imm}, 2 * $urandom_range(0, 15));
                2: v = ror({22'd0, $urandom_range(0, 1023)}, $urandom_range(0, 31));
                default: v = $urandom;
            endcase
            send(v);
        end
        drain();
        chk("queue_empty1", exp_q1.size(), 32'd0);
        chk("queue_empty0", exp_q0.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
